cmp8_minmax_tracker: RTL and testbench

//   Streaming consumer of 8-bit magnitude comparisons. Accepts samples over a valid/ready

---
 rtl/cmp8_minmax_tracker.sv | 111 +++++++++++
 tb/tb_cmp8_minmax_tracker.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/cmp8_minmax_tracker.sv
// Running min/max/count tracker for a stream of unsigned samples, with per-sample
// relation pulses against the previous sample and the current extremes.
module cmp8_minmax_tracker #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] min_out,
  output logic [WIDTH-1:0] max_out,
  output logic [CNT_W-1:0] count,
  output logic             have_data,
  output logic             full,
  output logic             i,
  output logic             j,
  output logic             k,
  output logic             new_max,
  output logic             new_min
);

  typedef enum logic [1:0] {EMPTY = 2'd0, RUN = 2'd1, HOLD = 2'd2} state_t;

  typedef struct packed {
    logic gt;
    logic lt;
    logic eq;
    logic nmax;
    logic nmin;
  } flags_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state, state_nxt;
  flags_t           flags;
  logic [WIDTH-1:0] prev;
  logic [CNT_W-1:0] cnt_inc;
  logic             accept;

  assign accept  = in_valid && in_ready;
  // count is zero in EMPTY, so the increment also yields the first-sample count of 1
  assign cnt_inc = count + CNT_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (clr) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY, RUN: if (accept) state_nxt = (cnt_inc == CNT_MAX) ? HOLD : RUN;
        HOLD:       state_nxt = HOLD;
        default:    state_nxt = EMPTY;
      endcase
    end
  end

  always_comb begin
    in_ready  = (state != HOLD) && !clr;
    have_data = (state != EMPTY);
    full      = (state == HOLD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      min_out <= '0;
      max_out <= '0;
      prev    <= '0;
      count   <= '0;
      flags   <= '0;
    end else begin
      flags <= '0;
      if (clr) begin
        min_out <= '0;
        max_out <= '0;
        prev    <= '0;
        count   <= '0;
      end else if (accept) begin
        count <= cnt_inc;
        prev  <= data_in;
        if (state == EMPTY) begin
          min_out <= data_in;
          max_out <= data_in;
          flags   <= '{gt: 1'b0, lt: 1'b0, eq: 1'b0, nmax: 1'b1, nmin: 1'b1};
        end else begin
          if (data_in > max_out) max_out <= data_in;
          if (data_in < min_out) min_out <= data_in;
          flags <= '{gt:   data_in > prev,
                     lt:   data_in < prev,
                     eq:   data_in == prev,
                     nmax: data_in > max_out,
                     nmin: data_in < min_out};
        end
      end
    end
  end

  assign i       = flags.gt;
  assign j       = flags.lt;
  assign k       = flags.eq;
  assign new_max = flags.nmax;
  assign new_min = flags.nmin;

endmodule

// File: tb/tb_cmp8_minmax_tracker.sv
// Directed bench for cmp8_minmax_tracker: two instances (CNT_W=8 and CNT_W=2) checked
// every cycle against a sample-history model, plus hand-computed literal expectations.
module tb_cmp8_minmax_tracker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clr = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] data_in = 8'd0;

  logic       rdy_a, hd_a, fl_a, i_a, j_a, k_a, nx_a, nn_a;
  logic [7:0] mn_a, mx_a, cnt_a;
  logic       rdy_b, hd_b, fl_b, i_b, j_b, k_b, nx_b, nn_b;
  logic [7:0] mn_b, mx_b;
  logic [1:0] cnt_b;

  int n_tests = 0;
  int n_fail  = 0;

  cmp8_minmax_tracker #(.WIDTH(8), .CNT_W(8)) u_dut_a (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(rdy_a),
    .data_in(data_in), .min_out(mn_a), .max_out(mx_a), .count(cnt_a),
    .have_data(hd_a), .full(fl_a), .i(i_a), .j(j_a), .k(k_a),
    .new_max(nx_a), .new_min(nn_a));

  cmp8_minmax_tracker #(.WIDTH(8), .CNT_W(2)) u_dut_b (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(rdy_b),
    .data_in(data_in), .min_out(mn_b), .max_out(mx_b), .count(cnt_b),
    .have_data(hd_b), .full(fl_b), .i(i_b), .j(j_b), .k(k_b),
    .new_max(nx_b), .new_min(nn_b));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Model: the accepted-sample history; outputs are derived from it directly.
  int       q [2][$];
  int       cap [2] = '{255, 3};
  bit [4:0] mp [2];   // {i,j,k,new_max,new_min}
  int       mv;

  function automatic int qmin(input int d);
    int r;
    if (q[d].size() == 0) return 0;
    r = q[d][0];
    foreach (q[d][n]) if (q[d][n] < r) r = q[d][n];
    return r;
  endfunction

  function automatic int qmax(input int d);
    int r;
    if (q[d].size() == 0) return 0;
    r = q[d][0];
    foreach (q[d][n]) if (q[d][n] > r) r = q[d][n];
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        q[d].delete();
        mp[d] = '0;
      end else begin
        mp[d] = '0;
        if (clr) begin
          q[d].delete();
        end else if (in_valid && q[d].size() < cap[d]) begin
          mv = int'(data_in);
          if (q[d].size() == 0) begin
            mp[d] = 5'b00011;
          end else begin
            mp[d][4] = mv >  q[d][$];
            mp[d][3] = mv <  q[d][$];
            mp[d][2] = mv == q[d][$];
            mp[d][1] = mv >  qmax(d);
            mp[d][0] = mv <  qmin(d);
          end
          q[d].push_back(mv);
        end
      end
    end
  end

  task automatic cmp_dut(input int d, input logic rdy, input logic hd, input logic fl,
                         input int cnt, input int mn, input int mx, input logic [4:0] pl);
    int sz;
    sz = q[d].size();
    chk($sformatf("d%0d in_ready", d),  int'(rdy), int'((sz < cap[d]) && !clr));
    chk($sformatf("d%0d have_data", d), int'(hd),  int'(sz > 0));
    chk($sformatf("d%0d full", d),      int'(fl),  int'(sz >= cap[d]));
    chk($sformatf("d%0d count", d),     cnt,       sz);
    chk($sformatf("d%0d min", d),       mn,        qmin(d));
    chk($sformatf("d%0d max", d),       mx,        qmax(d));
    chk($sformatf("d%0d pulses", d),    int'(pl),  int'(mp[d]));
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      cmp_dut(0, rdy_a, hd_a, fl_a, int'(cnt_a), int'(mn_a), int'(mx_a),
              {i_a, j_a, k_a, nx_a, nn_a});
      cmp_dut(1, rdy_b, hd_b, fl_b, int'(cnt_b), int'(mn_b), int'(mx_b),
              {i_b, j_b, k_b, nx_b, nn_b});
    end
  end

  // Drive one cycle's inputs, let the edge take them, land 1 time unit after it.
  task automatic cyc(input logic v, input logic [7:0] d, input logic c);
    in_valid = v;
    data_in  = d;
    clr      = c;
    @(posedge clk);
    #1;
  endtask

  function automatic int pa();
    return int'({i_a, j_a, k_a, nx_a, nn_a});
  endfunction

  initial begin
    #12 rst = 1'b0;
    @(posedge clk); #1;
    chk("reset count", int'(cnt_a), 0);
    chk("reset have_data", int'(hd_a), 0);
    chk("reset min/max", int'({mn_a, mx_a}), 0);
    chk("reset pulses", pa(), 0);
    chk("reset in_ready", int'(rdy_a), 1);

    // 22,12,22,22 back-to-back
    cyc(1, 8'd22, 0); chk("t1 s1 pulses", pa(), 5'b00011);
    cyc(1, 8'd12, 0); chk("t1 s2 pulses", pa(), 5'b01001);
    cyc(1, 8'd22, 0); chk("t1 s3 pulses", pa(), 5'b10000);
    cyc(1, 8'd22, 0); chk("t1 s4 pulses", pa(), 5'b00100);
    chk("t1 min", int'(mn_a), 12);
    chk("t1 max", int'(mx_a), 22);
    chk("t1 count", int'(cnt_a), 4);
    cyc(0, 8'd0, 0);  chk("t1 idle pulses", pa(), 0);

    // extremes 0/255 both directions
    cyc(0, 8'd0, 1);
    cyc(1, 8'd0, 0);
    cyc(1, 8'd255, 0); chk("t2 up pulses", pa(), 5'b10010);
    chk("t2 max", int'(mx_a), 255);
    chk("t2 min", int'(mn_a), 0);
    cyc(0, 8'd0, 1);
    cyc(1, 8'd255, 0);
    cyc(1, 8'd0, 0);   chk("t2 down pulses", pa(), 5'b01001);

    // CNT_W=2 saturation with in_valid held
    cyc(0, 8'd0, 1);
    cyc(1, 8'd10, 0);
    cyc(1, 8'd20, 0);
    cyc(1, 8'd30, 0);
    chk("t3 full", int'(fl_b), 1);
    chk("t3 count", int'(cnt_b), 3);
    chk("t3 in_ready", int'(rdy_b), 0);
    cyc(1, 8'd40, 0);
    chk("t3 count held", int'(cnt_b), 3);
    chk("t3 max held", int'(mx_b), 30);
    chk("t3 min held", int'(mn_b), 10);
    chk("t3 no pulse", int'({i_b, j_b, k_b, nx_b, nn_b}), 0);

    // clr beats a presented sample
    in_valid = 1'b1; data_in = 8'd5; clr = 1'b1; #1;
    chk("t4 in_ready during clr", int'(rdy_a), 0);
    @(posedge clk); #1;
    chk("t4 have_data", int'(hd_a), 0);
    chk("t4 count", int'(cnt_a), 0);
    cyc(1, 8'd5, 0);
    chk("t4 min", int'(mn_a), 5);
    chk("t4 max", int'(mx_a), 5);

    // async rst between edges
    cyc(1, 8'd7, 0);
    cyc(0, 8'd0, 0);
    #2 rst = 1'b1;
    #1;
    chk("t5 async count", int'(cnt_a), 0);
    chk("t5 async min/max", int'({mn_a, mx_a}), 0);
    chk("t5 async pulses", pa(), 0);
    chk("t5 async have_data", int'(hd_a), 0);
    rst = 1'b0;
    @(posedge clk); #1;
    cyc(1, 8'd3, 0);
    chk("t5 first after rst", pa(), 5'b00011);
    chk("t5 count", int'(cnt_a), 1);

    // gapped in_valid
    cyc(0, 8'd0, 1);
    cyc(1, 8'd50, 0); chk("t6 a pulses", pa(), 5'b00011);
    cyc(0, 8'd0, 0);  chk("t6 gap1", pa(), 0);
    cyc(0, 8'd0, 0);  chk("t6 gap2", pa(), 0);
    cyc(1, 8'd60, 0); chk("t6 b pulses", pa(), 5'b10010);
    chk("t6 count", int'(cnt_a), 2);
    cyc(0, 8'd0, 0);  chk("t6 idle", pa(), 0);

    // CNT_W=8 saturation at 255, no wrap
    cyc(0, 8'd0, 1);
    for (int n = 0; n < 260; n++) cyc(1, 8'(n * 37), 0);
    chk("sat count", int'(cnt_a), 255);
    chk("sat full", int'(fl_a), 1);
    chk("sat in_ready", int'(rdy_a), 0);
    cyc(0, 8'd0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
